maxpool_unit: RTL and testbench

MAXPOOL_UNIT -- requirements
Module: maxpool_unit

---
 rtl/maxpool_pkg.sv | 23 ++
 rtl/max_cmp.sv | 23 ++
 rtl/maxpool_unit.sv | 148 ++++++++++++++
 tb/tb_maxpool_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared constants for the 2x2 max-pooling unit: geometry, memory-select codes, FSM states.
package maxpool_pkg;

  localparam int unsigned DATA_W = 20;
  localparam int unsigned L0_DIM = 64;
  localparam int unsigned L1_DIM = L0_DIM / 2;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t RD0  = 3'd1;
  localparam state_t RD1  = 3'd2;
  localparam state_t RD2  = 3'd3;
  localparam state_t RD3  = 3'd4;
  localparam state_t CAP  = 3'd5;
  localparam state_t WR   = 3'd6;
  localparam state_t DONE = 3'd7;

endpackage

// File: rtl/max_cmp.sv
// Running unsigned maximum register; clr zeroes it, en folds in a new sample.
module max_cmp #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (d > q)) begin
      q <= d;
    end
  end

endmodule

// File: rtl/maxpool_unit.sv
// 2x2 max-pooling of the layer-0 image into layer-1, tracking the global maximum and its position.
module maxpool_unit #(
  parameter int unsigned DATA_W = maxpool_pkg::DATA_W,
  parameter int unsigned L0_DIM = maxpool_pkg::L0_DIM
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                crd,
  output logic [$clog2(L0_DIM*L0_DIM)-1:0]    caddr_rd,
  input  logic [DATA_W-1:0]                   cdata_rd,
  output logic                                cwr,
  output logic [$clog2(L0_DIM*L0_DIM)-1:0]    caddr_wr,
  output logic [DATA_W-1:0]                   cdata_wr,
  output logic [2:0]                          csel,
  output logic [DATA_W-1:0]                   max_value,
  output logic [$clog2(L0_DIM/2)-1:0]         x_m,
  output logic [$clog2(L0_DIM/2)-1:0]         y_m
);

  import maxpool_pkg::*;

  localparam int unsigned AW   = $clog2(L0_DIM * L0_DIM);
  localparam int unsigned CW   = $clog2(L0_DIM / 2);
  localparam int unsigned OW   = 2 * CW;
  localparam int unsigned NOUT = (L0_DIM / 2) * (L0_DIM / 2);

  state_t          state_q, state_d;
  logic [OW-1:0]   idx_q, idx_d;
  logic            busy_d, done_d, crd_d, cwr_d;
  logic [2:0]      csel_d;
  logic [AW-1:0]   base_d, caddr_rd_d, caddr_wr_d;
  logic            win_clr, win_en;
  logic [DATA_W-1:0] win_max;

  // Next state and output decode; outputs are computed for the upcoming state and registered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = CSEL_NONE;
    caddr_rd_d = '0;
    caddr_wr_d = '0;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = RD0;
      end
      RD0:  state_d = RD1;
      RD1:  state_d = RD2;
      RD2:  state_d = RD3;
      RD3:  state_d = CAP;
      CAP:  state_d = WR;
      WR: begin
        if (idx_q == OW'(NOUT - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RD0;
          idx_d   = idx_q + OW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Top-left corner of the 2x2 window for output idx_d.
    base_d = AW'({idx_d[OW-1:CW], 1'b0}) * AW'(L0_DIM) + AW'({idx_d[CW-1:0], 1'b0});

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    cwr_d  = (state_d == WR);
    case (state_d)
      RD0: begin crd_d = 1'b1; caddr_rd_d = base_d; end
      RD1: begin crd_d = 1'b1; caddr_rd_d = base_d + AW'(1); end
      RD2: begin crd_d = 1'b1; caddr_rd_d = base_d + AW'(L0_DIM); end
      RD3: begin crd_d = 1'b1; caddr_rd_d = base_d + AW'(L0_DIM + 1); end
      default: caddr_rd_d = '0;
    endcase

    if (crd_d)      csel_d = CSEL_L0;
    else if (cwr_d) csel_d = CSEL_L1;

    if (cwr_d) caddr_wr_d = AW'(idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= CSEL_NONE;
      caddr_rd <= '0;
      caddr_wr <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      crd      <= crd_d;
      cwr      <= cwr_d;
      csel     <= csel_d;
      caddr_rd <= caddr_rd_d;
      caddr_wr <= caddr_wr_d;
    end
  end

  // Read data lags its strobe by one cycle, so samples land during RD1..CAP.
  assign win_clr = (state_q == RD0);
  assign win_en  = (state_q == RD1) || (state_q == RD2) || (state_q == RD3) || (state_q == CAP);

  max_cmp #(.W(DATA_W)) u_max_cmp (
    .clk   (clk),
    .reset (reset),
    .clr   (win_clr),
    .en    (win_en),
    .d     (cdata_rd),
    .q     (win_max)
  );

  assign cdata_wr = win_max;

  // Global maximum: strict compare keeps the earliest output on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_value <= '0;
      x_m       <= '0;
      y_m       <= '0;
    end else if ((state_q == IDLE) && start) begin
      max_value <= '0;
      x_m       <= '0;
      y_m       <= '0;
    end else if ((state_q == WR) && (win_max > max_value)) begin
      max_value <= win_max;
      x_m       <= idx_q[CW-1:0];
      y_m       <= idx_q[OW-1:CW];
    end
  end

endmodule

// File: tb/tb_maxpool_unit.sv
// Scoreboard bench for maxpool_unit: memory models, protocol monitor and directed image patterns.
module tb_maxpool_unit;

  typedef struct packed {
    logic [11:0] addr;
    logic [19:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, crd, cwr;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd = '0;
  logic [19:0] cdata_wr, max_value;
  logic [2:0]  csel;
  logic [4:0]  x_m, y_m;

  logic [19:0] l0_mem [4096];
  logic [19:0] l1_mem [1024];
  wr_t         sb_q [$];
  wr_t         sb_e;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, proto_err = 0;
  logic [19:0] exp_max;
  int exp_x, exp_y;

  always #5 clk = ~clk;

  maxpool_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .cwr       (cwr),
    .caddr_wr  (caddr_wr),
    .cdata_wr  (cdata_wr),
    .csel      (csel),
    .max_value (max_value),
    .x_m       (x_m),
    .y_m       (y_m)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory models: registered read, write on strobe.
  always @(posedge clk) begin
    if (crd) cdata_rd <= l0_mem[caddr_rd];
    if (cwr) l1_mem[caddr_wr[9:0]] <= cdata_wr;
  end

  // Protocol monitor and scoreboard compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (crd) rd_cnt++;
      if (cwr) wr_cnt++;
      if (busy) busy_cnt++;
      if ((crd && cwr) || (crd && csel != 3'b001) || (cwr && csel != 3'b011) ||
          (!crd && !cwr && csel != 3'b000))
        proto_err++;
      if (cwr) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_write", 64'(caddr_wr), 64'hFFFF);
        end else begin
          sb_e = sb_q.pop_front();
          chk("wr_addr", 64'(caddr_wr), 64'(sb_e.addr));
          chk("wr_data", 64'(cdata_wr), 64'(sb_e.data));
        end
      end
    end
  end

  // Reference: pool each 2x2 block by row/column, track strict global max in row-major order.
  task automatic push_expected();
    logic [19:0] m, v;
    exp_max = '0; exp_x = 0; exp_y = 0;
    for (int oy = 0; oy < 32; oy++) begin
      for (int ox = 0; ox < 32; ox++) begin
        m = '0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            v = l0_mem[(2*oy + dy)*64 + 2*ox + dx];
            if (v > m) m = v;
          end
        sb_q.push_back('{addr: 12'(oy*32 + ox), data: m});
        if (m > exp_max) begin
          exp_max = m; exp_x = ox; exp_y = oy;
        end
      end
    end
  endtask

  task automatic pulse_start();
    rd_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("max_clear", 64'({max_value, x_m, y_m}), 64'd0);
  endtask

  task automatic run_case(input string tag, input bit mid_start, input bit done_start);
    int cyc;
    logic [19:0] held;
    push_expected();
    pulse_start();
    cyc = 0;
    while (done !== 1'b1 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      start = (mid_start && cyc == 3000);
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_max_value"}, 64'(max_value), 64'(exp_max));
    chk({tag, "_x_m"}, 64'(x_m), 64'(exp_x));
    chk({tag, "_y_m"}, 64'(y_m), 64'(exp_y));
    chk({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    chk({tag, "_reads"}, 64'(rd_cnt), 64'd4096);
    chk({tag, "_writes"}, 64'(wr_cnt), 64'd1024);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd6144);
    chk({tag, "_protocol"}, 64'(proto_err), 64'd0);
    held = max_value;
    start = done_start;
    @(negedge clk) start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "_max_hold"}, 64'(max_value), 64'(held));
    sb_q.delete();
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, crd, cwr, csel}), 64'd0);
    chk("rst_addr", 64'({caddr_rd, caddr_wr}), 64'd0);
    chk("rst_data", 64'({cdata_wr, max_value, x_m, y_m}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int a = 0; a < 4096; a++) l0_mem[a] = '0;
    run_case("zero", 1'b0, 1'b0);

    for (int a = 0; a < 4096; a++) l0_mem[a] = 20'(a);
    run_case("ramp", 1'b0, 1'b1);
    chk("ramp_l1_0", 64'(l1_mem[0]), 64'd65);
    chk("ramp_l1_1023", 64'(l1_mem[1023]), 64'hFFF);

    for (int a = 0; a < 4096; a++) l0_mem[a] = 20'd1;
    l0_mem[1291] = 20'hFFFFF;
    run_case("peak", 1'b0, 1'b0);
    chk("peak_l1_325", 64'(l1_mem[325]), 64'hFFFFF);
    chk("peak_l1_324", 64'(l1_mem[324]), 64'd1);

    for (int a = 0; a < 4096; a++) l0_mem[a] = '0;
    l0_mem[6]    = 20'h00100;
    l0_mem[2809] = 20'h00100;
    run_case("tie", 1'b0, 1'b0);

    // Abort a run with reset part-way through, then rerun with random data.
    for (int a = 0; a < 4096; a++) l0_mem[a] = 20'(a);
    push_expected();
    pulse_start();
    cyc = 0;
    while (busy_cnt < 1000 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", 64'(busy_cnt >= 1000), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_ctrl", 64'({busy, done, crd, cwr, csel}), 64'd0);
    chk("abort_addr", 64'({caddr_rd, caddr_wr}), 64'd0);
    chk("abort_data", 64'({cdata_wr, max_value, x_m, y_m}), 64'd0);
    sb_q.delete();
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4096; a++) l0_mem[a] = 20'($urandom);
    run_case("rand", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
